pc_sequencer: RTL and testbench

Next-PC controller for the five-stage flow CPU. It owns the fetch address register and decides each cycle whether the PC advances by 4, holds for a hazard stall or instruction-memory wait, or redirects to a branch, jump or jr target. It generates the IF/ID flush and fetch-valid strobes and keeps a saturating redirect counter for debug. It sits between the hazard unit, the ID/EX branch-resolution logic and the instruction memory.

---
 rtl/pc_sequencer.sv | 103 ++++++++++
 tb/tb_pc_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch address, sequences BOOT/RUN/REDIR_PEND,
// drives IF/ID fetch-valid and flush strobes, and counts accepted redirects.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        pc_clk,
  input  logic        rst,
  input  logic        imem_ready,
  input  logic        stall_req,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush_if,
  output logic [15:0] redirect_count
);

  typedef enum logic [1:0] {BOOT, RUN, REDIR_PEND} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pend_reg, pend_next;
  logic [15:0] count_reg;
  logic        redir;
  logic [31:0] raw_target, target;

  assign redir    = br_taken | jr_en | jump_en;
  // EX-stage branch is the oldest instruction, so it wins over ID-stage jumps.
  assign raw_target = br_taken ? br_target : (jr_en ? jr_target : jump_target);
  assign target   = {raw_target[31:2], 2'b00};
  assign pc_plus4 = pc_reg + 32'd4;
  assign pc       = pc_reg;
  assign redirect_count = count_reg;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    pend_next   = pend_reg;
    fetch_valid = 1'b0;
    flush_if    = 1'b0;
    case (state_reg)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        if (redir) begin
          flush_if = 1'b1;
          if (imem_ready) begin
            pc_next = target;
          end else begin
            pend_next  = target;
            state_next = REDIR_PEND;
          end
        end else if (!stall_req && imem_ready) begin
          pc_next     = pc_plus4;
          fetch_valid = 1'b1;
        end
      end
      REDIR_PEND: begin
        // Newest redirect replaces the parked target; stalls are irrelevant here.
        if (redir) begin
          flush_if  = 1'b1;
          pend_next = target;
          if (imem_ready) begin
            pc_next    = target;
            state_next = RUN;
          end
        end else if (imem_ready) begin
          pc_next    = pend_reg;
          state_next = RUN;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
    if (rst) begin
      fetch_valid = 1'b0;
      flush_if    = 1'b0;
    end
  end

  always_ff @(posedge pc_clk) begin
    if (rst) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
      pend_reg  <= 32'h0000_0000;
      count_reg <= 16'h0000;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      pend_reg  <= pend_next;
      if (flush_if && (count_reg != 16'hFFFF))
        count_reg <= count_reg + 16'd1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: one table row per cycle, plus a
// long redirect burst to reach counter saturation.
module tb_pc_sequencer;

  logic        pc_clk;
  logic        rst;
  logic        imem_ready;
  logic        stall_req;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jr_en;
  logic [31:0] jr_target;
  logic        jump_en;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush_if;
  logic [15:0] redirect_count;

  int checks = 0;
  int failures = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .pc_clk(pc_clk), .rst(rst), .imem_ready(imem_ready), .stall_req(stall_req),
    .br_taken(br_taken), .br_target(br_target), .jr_en(jr_en), .jr_target(jr_target),
    .jump_en(jump_en), .jump_target(jump_target), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .flush_if(flush_if), .redirect_count(redirect_count)
  );

  initial begin
    pc_clk = 1'b0;
    forever #5 pc_clk = ~pc_clk;
  end

  typedef struct {
    logic        rst, rdy, stl, br;
    logic [31:0] brt;
    logic        jr;
    logic [31:0] jrt;
    logic        j;
    logic [31:0] jt;
    logic [31:0] epc;
    logic        efv, efl;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic rd, logic s, logic b, logic [31:0] bt,
                              logic jre, logic [31:0] jrtv, logic je, logic [31:0] jtv,
                              logic [31:0] p, logic fv, logic fl, logic [15:0] c);
    vec_t v;
    v.rst = r; v.rdy = rd; v.stl = s; v.br = b; v.brt = bt;
    v.jr = jre; v.jrt = jrtv; v.j = je; v.jt = jtv;
    v.epc = p; v.efv = fv; v.efl = fl; v.ecnt = c;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%08h expected=0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; imem_ready = v.rdy; stall_req = v.stl;
    br_taken = v.br; br_target = v.brt;
    jr_en = v.jr; jr_target = v.jrt;
    jump_en = v.j; jump_target = v.jt;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; imem_ready = 1'b1; stall_req = 1'b0;
    br_taken = 1'b0; br_target = '0; jr_en = 1'b0; jr_target = '0;
    jump_en = 1'b0; jump_target = '0;
  endtask

  initial begin
    //                rst rdy stl br brt          jr jrt        j  jt             pc            fv fl cnt
    vecs.push_back(mk(1, 1, 0, 0, 0,            0, 0,         0, 0,            32'h0,        0, 0, 0));  // reset state
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         0, 0,            32'h0,        0, 0, 0));  // BOOT
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         0, 0,            32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         0, 0,            32'h4,        1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         0, 0,            32'h8,        1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         0, 0,            32'hC,        1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         1, 32'h40,       32'h10,       0, 1, 0));  // jump to 0x40
    vecs.push_back(mk(0, 1, 1, 0, 0,            0, 0,         0, 0,            32'h40,       0, 0, 1));  // stall
    vecs.push_back(mk(0, 1, 1, 0, 0,            0, 0,         0, 0,            32'h40,       0, 0, 1));  // stall
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         0, 0,            32'h40,       1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 32'h40,       0, 0,         0, 0,            32'h44,       0, 1, 1));  // back to 0x40
    vecs.push_back(mk(0, 1, 1, 1, 32'h100,      0, 0,         1, 32'h200,      32'h40,       0, 1, 2));  // br beats j and stall
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         0, 0,            32'h100,      1, 0, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         1, 32'h40,       32'h104,      0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 32'h303,   0, 0,            32'h40,       0, 1, 4));  // jr, not ready
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0,         0, 0,            32'h40,       0, 0, 5));  // REDIR_PEND 1
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0,         0, 0,            32'h40,       0, 0, 5));  // REDIR_PEND 2
    vecs.push_back(mk(0, 1, 1, 0, 0,            0, 0,         0, 0,            32'h40,       0, 0, 5));  // REDIR_PEND 3, stall ignored
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         0, 0,            32'h300,      1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 1, 32'h302,      0, 0,         0, 0,            32'h304,      0, 1, 5));  // pend 0x300
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0,         1, 32'h500,      32'h304,      0, 1, 6));  // overwrite pend 0x500
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         0, 0,            32'h304,      0, 0, 7));
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         0, 0,            32'h500,      1, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 32'h600,   0, 0,            32'h504,      0, 1, 7));  // pend 0x600
    vecs.push_back(mk(0, 1, 0, 1, 32'h700,      1, 32'h800,   0, 0,            32'h504,      0, 1, 8));  // ready + new redir
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         0, 0,            32'h700,      1, 0, 9));
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         1, 32'hFFFF_FFFC, 32'h704,     0, 1, 9));
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         0, 0,            32'hFFFF_FFFC, 1, 0, 10)); // wrap
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0,         0, 0,            32'h0,        0, 0, 10)); // imem wait
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         0, 0,            32'h0,        1, 0, 10));
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0,         1, 32'h900,      32'h4,        0, 1, 10)); // into REDIR_PEND
    vecs.push_back(mk(1, 1, 0, 0, 0,            0, 0,         1, 32'hA00,      32'h4,        0, 0, 11)); // rst in REDIR_PEND
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         1, 32'hB00,      32'h0,        0, 0, 0));  // BOOT ignores redir
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         1, 32'h40,       32'h0,        0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,         0, 0,            32'h40,       1, 0, 1));

    idle_inputs();
    rst = 1'b1;
    @(posedge pc_clk);
    @(negedge pc_clk);

    foreach (vecs[i]) begin
      logic [31:0] exp_p4;
      drive(vecs[i]);
      #1;
      exp_p4 = vecs[i].epc + 32'd4;
      check("pc", i, pc, vecs[i].epc);
      check("pc_plus4", i, pc_plus4, exp_p4);
      check("fetch_valid", i, {31'd0, fetch_valid}, {31'd0, vecs[i].efv});
      check("flush_if", i, {31'd0, flush_if}, {31'd0, vecs[i].efl});
      check("redirect_count", i, {16'd0, redirect_count}, {16'd0, vecs[i].ecnt});
      $display("step %0d pc=0x%08h fv=%0b fl=%0b cnt=%0d", i, pc, fetch_valid, flush_if, redirect_count);
      @(posedge pc_clk);
      @(negedge pc_clk);
    end

    // Redirect every cycle until the counter reaches 0xFFFF (starts at 1).
    idle_inputs();
    jump_en = 1'b1;
    jump_target = 32'h80;
    for (int k = 0; k < 65534; k++) @(posedge pc_clk);
    @(negedge pc_clk);
    check("sat_reach", 100, {16'd0, redirect_count}, 32'h0000_FFFF);
    check("sat_flush", 101, {31'd0, flush_if}, 32'd1);
    $display("saturation cnt=0x%04h pc=0x%08h", redirect_count, pc);
    @(posedge pc_clk);
    @(negedge pc_clk);
    check("sat_hold", 102, {16'd0, redirect_count}, 32'h0000_FFFF);
    check("sat_pc", 103, pc, 32'h80);
    $display("saturation hold cnt=0x%04h", redirect_count);

    rst = 1'b1;
    @(posedge pc_clk);
    @(negedge pc_clk);
    check("rst_cnt", 104, {16'd0, redirect_count}, 32'd0);
    check("rst_pc", 105, pc, 32'h0);
    $display("final reset cnt=%0d pc=0x%08h", redirect_count, pc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
